store_narrower: RTL and testbench

- Store-path counterpart of the load-side sign extension in the pipelined LEGv8 CPU.
- Takes a 64-bit register value plus a store size (STURB/STURH/STURW/STUR) and writes the selected low bytes to a byte-wide data memory port, one byte per accepted cycle, little-endian.
- Sits between the EX/MEM stage and the byte-wide data RAM.
- Flags when the narrowed value does not sign-extend back to the original register value.

---
 rtl/store_narrower_pkg.sv | 22 ++
 rtl/sign_ext.sv | 12 +
 rtl/store_ovf_check.sv | 29 ++
 rtl/store_narrower.sv | 106 ++++++++++
 tb/tb_store_narrower.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/store_narrower_pkg.sv
// Shared types for the byte-wide store path: store size encoding, FSM states
// and the size-to-byte-count helper.
package store_narrower_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [3:0] bytes_for_size(input size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/sign_ext.sv
// Generic sign extension of an IN_W-bit value to OUT_W bits.
module sign_ext #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 64
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/store_ovf_check.sv
// Flags a store whose truncated value does not sign-extend back to the full
// 64-bit register value. Purely combinational.
module store_ovf_check
  import store_narrower_pkg::*;
(
  input  logic [63:0] value,
  input  size_e       size,
  output logic        ovf
);

  logic [63:0] ext_b;
  logic [63:0] ext_h;
  logic [63:0] ext_w;

  sign_ext #(.IN_W(8),  .OUT_W(64)) u_ext_b (.din(value[7:0]),  .dout(ext_b));
  sign_ext #(.IN_W(16), .OUT_W(64)) u_ext_h (.din(value[15:0]), .dout(ext_h));
  sign_ext #(.IN_W(32), .OUT_W(64)) u_ext_w (.din(value[31:0]), .dout(ext_w));

  always_comb begin
    ovf = 1'b0;
    case (size)
      SZ_BYTE:   ovf = (ext_b != value);
      SZ_HALF:   ovf = (ext_h != value);
      SZ_WORD:   ovf = (ext_w != value);
      default:   ovf = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_narrower.sv
// Narrows a 64-bit store to 1/2/4/8 bytes and streams them little-endian to
// a byte-wide memory port, one byte per accepted cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a new store; inputs latched on start
// ST_WRITE | driving byte idx at base+idx, advances on mem_ready
// ST_DONE  | one-cycle done pulse with ovf valid, then back to idle
module store_narrower
  import store_narrower_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            size,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [63:0]           wdata,
  output logic                  ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ready,
  output logic                  done,
  output logic                  ovf
);

  state_e                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  size_e                 size_q, size_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [63:0]           wdata_q, wdata_d;

  logic                  ovf_raw;
  logic                  last_byte;

  store_ovf_check u_ovf (
    .value (wdata_q),
    .size  (size_q),
    .ovf   (ovf_raw)
  );

  assign last_byte = ({1'b0, idx_q} == (bytes_for_size(size_q) - 4'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      size_q  <= SZ_BYTE;
      base_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      size_q  <= size_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs are decoded from the registered state only, so a reset clears
  // the memory port in the same instant it is asserted.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    size_d    = size_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    ready     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    ovf       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          size_d  = size_e'(size);
          base_d  = base_addr;
          wdata_d = wdata;
          idx_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + ADDR_WIDTH'(idx_q);
        mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
        if (mem_ready) begin
          if (last_byte) state_d = ST_DONE;
          else           idx_d   = idx_q + 3'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        ovf     = ovf_raw;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_narrower.sv
// Directed bench for store_narrower with a write/ovf scoreboard filled at
// acceptance and drained as the memory port accepts bytes.
module tb_store_narrower;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  size;
  logic [63:0] base_addr;
  logic [63:0] wdata;
  logic        ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        done;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  logic [63:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic        exp_ovf[$];
  int          acc_cyc[$];

  store_narrower #(.ADDR_WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .size      (size),
    .base_addr (base_addr),
    .wdata     (wdata),
    .ready     (ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_fail(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=event expected=none", tag);
  endtask

  task automatic push_model(input logic [1:0] sz, input logic [63:0] base, input logic [63:0] wd);
    int nb;
    int sh;
    logic signed [63:0] t;
    nb = 1 << sz;
    sh = 64 - 8 * nb;
    for (int i = 0; i < nb; i++) begin
      exp_addr.push_back(base + 64'(i));
      exp_data.push_back(8'(wd >> (8 * i)));
    end
    t = $signed(wd << sh) >>> sh;
    exp_ovf.push_back(t !== $signed(wd));
  endtask

  // Checks the current cycle's outputs, then advances one clock.
  task automatic obs_step(output bit saw_done);
    saw_done = done;
    if (mem_we) begin
      if (exp_addr.size() == 0) sb_fail("unexpected_write");
      else begin
        chk("mem_addr", mem_addr, exp_addr[0]);
        chk("mem_wdata", 64'(mem_wdata), 64'(exp_data[0]));
        if (mem_ready) begin
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
        end
      end
    end else begin
      chk("idle_addr", mem_addr, 64'd0);
      chk("idle_wdata", 64'(mem_wdata), 64'd0);
    end
    if (done) begin
      done_cnt++;
      if (exp_ovf.size() == 0) sb_fail("unexpected_done");
      else chk("ovf", 64'(ovf), 64'(exp_ovf.pop_front()));
    end else begin
      chk("ovf_low", 64'(ovf), 64'd0);
    end
    if (start && ready) begin
      push_model(size, base_addr, wdata);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [1:0] sz, input logic [63:0] base, input logic [63:0] wd);
    bit d;
    chk("ready_before_issue", 64'(ready), 64'd1);
    size      = sz;
    base_addr = base;
    wdata     = wd;
    start     = 1'b1;
    mem_ready = 1'b1;
    obs_step(d);
    start = 1'b0;
  endtask

  task automatic run_to_done(input int limit, input int st_lo, input int st_hi, output int k);
    bit d;
    k = 0;
    do begin
      k++;
      mem_ready = (k >= st_lo && k <= st_hi) ? 1'b0 : 1'b1;
      obs_step(d);
    end while (!d && k < limit);
    if (!d) sb_fail("done_timeout");
    mem_ready = 1'b1;
  endtask

  initial begin
    int  k;
    bit  d;
    int  dc;

    reset = 1'b1; start = 1'b0; size = 2'd0; base_addr = '0; wdata = '0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    @(posedge clk);
    #1;

    // byte store, positive value
    issue(2'd0, 64'h100, 64'h7F);
    run_to_done(20, 0, -1, k);
    chk("lat_byte", 64'(k), 64'd2);

    // half store that overflows; inputs scrambled during WRITE must not matter
    issue(2'd1, 64'h200, 64'h8000);
    wdata = '1; base_addr = '0; size = 2'd3;
    run_to_done(20, 0, -1, k);
    chk("lat_half", 64'(k), 64'd3);

    // double store with a 2-cycle stall on the third byte
    issue(2'd3, 64'h300, 64'h0123_4567_89AB_CDEF);
    run_to_done(30, 3, 4, k);
    chk("lat_double_stall", 64'(k), 64'd11);

    // word store wrapping past the top of the address space
    issue(2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_8000_0001);
    run_to_done(20, 0, -1, k);
    chk("lat_word_wrap", 64'(k), 64'd5);
    chk("sb_empty_1", 64'(exp_addr.size()), 64'd0);

    // reset after two bytes of a double store aborts it
    issue(2'd3, 64'h500, 64'h1122_3344_5566_7788);
    mem_ready = 1'b1;
    obs_step(d);
    obs_step(d);
    chk("pre_abort_remaining", 64'(exp_addr.size()), 64'd6);
    reset = 1'b1;
    #1;
    chk("abort_mem_we", 64'(mem_we), 64'd0);
    chk("abort_mem_addr", mem_addr, 64'd0);
    chk("abort_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    exp_addr.delete(); exp_data.delete(); exp_ovf.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    dc = done_cnt;
    for (int i = 0; i < 12; i++) obs_step(d);
    chk("abort_no_done", 64'(done_cnt - dc), 64'd0);

    // start held high: byte stores back to back, one accepted every 3 cycles
    acc_cyc.delete();
    size = 2'd0; base_addr = 64'h600; wdata = 64'hFFFF_FFFF_FFFF_FF85;
    start = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) obs_step(d);
    start = 1'b0;
    chk("b2b_accepts", 64'(acc_cyc.size()), 64'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap0", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
      chk("b2b_gap1", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
    end
    for (int i = 0; i < 10 && !(ready && exp_ovf.size() == 0); i++) obs_step(d);
    chk("drain_writes", 64'(exp_addr.size()), 64'd0);
    chk("drain_ovf", 64'(exp_ovf.size()), 64'd0);
    chk("final_ready", 64'(ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
